// File: rtl/fold_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fold_pkg : shared types and fold recurrence for the check register |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package fold_pkg;

   localparam int CHECK_W = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FOLD_HOLD  = 2'd0,
      FOLD_CLEAR = 2'd1,
      FOLD_IN    = 2'd2,
      FOLD_DRAIN = 2'd3
   } fold_mode_t;

   // Identical recurrence to the receive-side register; keep them in lockstep.
   function automatic logic [CHECK_W-1:0] fold_step(input logic [CHECK_W-1:0] reg15,
                                                    input logic               din);
      return {din ^ reg15[0], reg15[CHECK_W-1:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fold_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fold_lfsr : 15-bit fold register, modes clear / fold-in / drain    |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module fold_lfsr
   import fold_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  fold_mode_t         mode,
   input  logic               bit_in,
   output logic [CHECK_W-1:0] fold_out
);

   logic [CHECK_W-1:0] fold_q;
   logic [CHECK_W-1:0] fold_d;

   always_comb begin
      fold_d = fold_q;
      case (mode)
         FOLD_CLEAR: fold_d = '0;
         FOLD_IN:    fold_d = fold_step(fold_q, bit_in);
         FOLD_DRAIN: fold_d = {1'b0, fold_q[CHECK_W-1:1]};
         default:    fold_d = fold_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fold_q <= '0;
      end else begin
         fold_q <= fold_d;
      end
   end

   assign fold_out = fold_q;

endmodule
`default_nettype wire

// File: rtl/fold_check_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fold_check_tx : serialise an N-bit word MSB-first, then append its |
// |                 15-bit fold check word LSB-first                   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module fold_check_tx
   import fold_pkg::*;
#(
   parameter int N  = 64,
   parameter int CW = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N-1:0]       data_in,
   output logic               ready,
   input  logic               shift,
   output logic               ser_out,
   output logic               ser_valid,
   output logic               frame_last,
   output logic [CW-1:0]      count,
   output logic [CHECK_W-1:0] check_out
);

   localparam logic [CW-1:0] DATA_LAST = CW'(N - 1);
   localparam logic [CW-1:0] FRAME_END = CW'(N + CHECK_W - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  sreg_q, sreg_d;
   logic [CW-1:0] count_q, count_d;
   fold_mode_t    fold_mode;
   logic [CHECK_W-1:0] fold_val;

   fold_lfsr u_fold (
      .clk      (clk),
      .rst      (rst),
      .mode     (fold_mode),
      .bit_in   (sreg_q[N-1]),
      .fold_out (fold_val)
   );

   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      count_d    = count_q;
      fold_mode  = FOLD_HOLD;
      ready      = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      frame_last = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               sreg_d    = data_in;
               count_d   = '0;
               fold_mode = FOLD_CLEAR;
               state_d   = DATA;
            end
         end
         DATA: begin
            ser_valid = 1'b1;
            ser_out   = sreg_q[N-1];
            if (shift) begin
               fold_mode = FOLD_IN;
               sreg_d    = {sreg_q[N-2:0], 1'b0};
               count_d   = count_q + CW'(1);
               if (count_q == DATA_LAST) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            ser_valid  = 1'b1;
            ser_out    = fold_val[0];
            frame_last = (count_q == FRAME_END);
            if (shift) begin
               fold_mode = FOLD_DRAIN;
               // Counter returns to zero so it never reports N+15 consumed bits.
               if (frame_last) begin
                  count_d = '0;
                  state_d = IDLE;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign check_out = fold_val;

endmodule
`default_nettype wire

// File: tb/tb_fold_check_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fold_check_tx : scoreboard bench for N=4 and N=64 instances     |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_fold_check_tx;

   typedef struct packed {
      logic        b;
      logic        last;
      logic [10:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start4 = 1'b0, shift4 = 1'b0;
   logic [3:0]  data4 = '0;
   logic        ready4, ser_out4, ser_valid4, frame_last4;
   logic [10:0] count4;
   logic [14:0] check4;

   logic        start64 = 1'b0, shift64 = 1'b0;
   logic [63:0] data64 = '0;
   logic        ready64, ser_out64, ser_valid64, frame_last64;
   logic [10:0] count64;
   logic [14:0] check64;

   int checks = 0;
   int errors = 0;
   int peak64 = 0;
   exp_t q4[$];
   exp_t q64[$];

   logic [18:0] c_frame4 = 19'b1011_00000000000_1011;

   always #5 clk = ~clk;

   fold_check_tx #(.N(4), .CW(11)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .data_in(data4), .ready(ready4),
      .shift(shift4), .ser_out(ser_out4), .ser_valid(ser_valid4),
      .frame_last(frame_last4), .count(count4), .check_out(check4)
   );

   fold_check_tx #(.N(64), .CW(11)) dut64 (
      .clk(clk), .rst(rst), .start(start64), .data_in(data64), .ready(ready64),
      .shift(shift64), .ser_out(ser_out64), .ser_valid(ser_valid64),
      .frame_last(frame_last64), .count(count64), .check_out(check64)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push4(input logic [18:0] bits, input int n_items);
      exp_t e;
      for (int i = 0; i < n_items; i++) begin
         e.b    = bits[18-i];
         e.last = (i == 18);
         e.cnt  = 11'(i);
         q4.push_back(e);
      end
   endtask

   task automatic push64_one;
      exp_t e;
      for (int i = 0; i < 79; i++) begin
         e.b    = (i == 63) || (i == 78);
         e.last = (i == 78);
         e.cnt  = 11'(i);
         q64.push_back(e);
      end
   endtask

   task automatic wait_ready4(input string name);
      int k = 0;
      while (!ready4 && k < 200) begin
         tick();
         k++;
      end
      chk(name, {31'd0, ready4}, 32'd1);
   endtask

   // Monitors: compare the presented bit against the queue head; pop on consume.
   always @(negedge clk) begin
      if (!rst && ser_valid4) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL mon4_unexpected: got bit %0b count %0d expected no output", ser_out4, count4);
         end else if (ser_out4 !== q4[0].b || frame_last4 !== q4[0].last || count4 !== q4[0].cnt) begin
            errors++;
            $display("FAIL mon4_bit: got bit %0b last %0b count %0d expected bit %0b last %0b count %0d",
                     ser_out4, frame_last4, count4, q4[0].b, q4[0].last, q4[0].cnt);
            if (shift4) void'(q4.pop_front());
         end else if (shift4) begin
            void'(q4.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ser_valid64) begin
         checks++;
         if (32'(count64) > peak64) peak64 = 32'(count64);
         if (q64.size() == 0) begin
            errors++;
            $display("FAIL mon64_unexpected: got bit %0b count %0d expected no output", ser_out64, count64);
         end else if (ser_out64 !== q64[0].b || frame_last64 !== q64[0].last || count64 !== q64[0].cnt) begin
            errors++;
            $display("FAIL mon64_bit: got bit %0b last %0b count %0d expected bit %0b last %0b count %0d",
                     ser_out64, frame_last64, count64, q64[0].b, q64[0].last, q64[0].cnt);
            if (shift64) void'(q64.pop_front());
         end else if (shift64) begin
            void'(q64.pop_front());
         end
      end
   end

   initial begin
      // Reset, then idle with shift held high.
      rst = 1'b1; shift4 = 1'b1; shift64 = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ready",     {31'd0, ready4},     32'd1);
         chk("idle_ser_valid", {31'd0, ser_valid4}, 32'd0);
         chk("idle_count",     {21'd0, count4},     32'd0);
         chk("idle_check",     {17'd0, check4},     32'd0);
      end
      chk("idle_ready64", {31'd0, ready64}, 32'd1);

      // N=4, 1011, shift held high.
      push4(c_frame4, 19);
      start4 = 1'b1; data4 = 4'b1011;
      tick();
      start4 = 1'b0;
      chk("b_ready_low", {31'd0, ready4},     32'd0);
      chk("b_valid",     {31'd0, ser_valid4}, 32'd1);
      repeat (4) tick();
      chk("b_check_after_data", {17'd0, check4}, 32'h6800);
      chk("b_count_after_data", {21'd0, count4}, 32'd4);
      repeat (14) tick();
      chk("b_frame_last", {31'd0, frame_last4}, 32'd1);
      chk("b_count_last", {21'd0, count4},      32'd18);
      tick();
      chk("b_ready_back", {31'd0, ready4},     32'd1);
      chk("b_valid_off",  {31'd0, ser_valid4}, 32'd0);
      chk("b_check_zero", {17'd0, check4},     32'd0);

      // N=64, data 1.
      push64_one();
      start64 = 1'b1; data64 = 64'h1;
      tick();
      start64 = 1'b0;
      repeat (64) tick();
      chk("c_check_after_data", {17'd0, check64}, 32'h4000);
      chk("c_count_after_data", {21'd0, count64}, 32'd64);
      repeat (14) tick();
      chk("c_frame_last", {31'd0, frame_last64}, 32'd1);
      chk("c_count_last", {21'd0, count64},      32'd78);
      tick();
      chk("c_ready_back", {31'd0, ready64}, 32'd1);
      chk("c_count_peak", 32'(peak64),      32'd78);

      // N=4, shift toggling every cycle.
      shift4 = 1'b0;
      push4(c_frame4, 19);
      start4 = 1'b1; data4 = 4'b1011;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 200 && !ready4; k++) begin
         shift4 = ~shift4;
         tick();
      end
      chk("d_ready_back", {31'd0, ready4}, 32'd1);

      // start during DATA with different data is ignored.
      shift4 = 1'b1;
      push4(c_frame4, 19);
      start4 = 1'b1; data4 = 4'b1011;
      tick();
      start4 = 1'b0;
      repeat (2) tick();
      start4 = 1'b1; data4 = 4'b0100;
      tick();
      start4 = 1'b0;
      wait_ready4("e_ready_back");

      // Reset at count 2 of the check phase, then a clean frame.
      push4(c_frame4, 6);
      start4 = 1'b1; data4 = 4'b1011;
      tick();
      start4 = 1'b0;
      repeat (6) tick();
      chk("f_count_before_rst", {21'd0, count4}, 32'd6);
      rst = 1'b1; shift4 = 1'b0;
      tick();
      rst = 1'b0;
      chk("f_ready",     {31'd0, ready4},     32'd1);
      chk("f_ser_valid", {31'd0, ser_valid4}, 32'd0);
      chk("f_check",     {17'd0, check4},     32'd0);
      chk("f_count",     {21'd0, count4},     32'd0);
      shift4 = 1'b1;
      push4(c_frame4, 19);
      start4 = 1'b1; data4 = 4'b1011;
      tick();
      start4 = 1'b0;
      repeat (4) tick();
      chk("f_clean_check", {17'd0, check4}, 32'h6800);
      wait_ready4("f_ready_back");

      tick(); tick();
      chk("q4_drained",  32'(q4.size()),  32'd0);
      chk("q64_drained", 32'(q64.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fold_check_tx.md
Name: fold_check_tx

Overview:
- Transmit-side counterpart of the 15-bit fold/check register that the receive path uses to compress a serial N-bit word.
- Accepts one parallel N-bit word and serialises it MSB-first, while running the same fold recurrence.
- Then appends the resulting 15-bit check word, so a downstream checker can recompute it and compare.
- Sits between the word source and the serial link/bench driver; per-bit advance is gated by a `shift` strobe.

Parameters:
- N, 64, data word width in bits; N+15 <= 2047.
- CW, 11, width of the bit counter output.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to send data_in; accepted only when ready=1.
- data_in  input  N  word to send, sampled on the accepted start cycle.
- ready  output  1  idle, able to accept start.
- shift  input  1  downstream consumed current ser_out; advance one bit.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is meaningful (state DATA or CHECK).
- frame_last  output  1  ser_out is the final (check bit 14) bit of the frame.
- count  output  CW  bits already consumed in the current frame (0..N+14).
- check_out  output  15  running fold register contents.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset (any state, including mid-frame):
  - state=IDLE, fold register=0, shift register=0, count=0.
  - ready=1, ser_valid=0, frame_last=0, ser_out=0.
  - No partial frame resumes after reset.
- States: IDLE -> DATA -> CHECK -> IDLE.
- IDLE:
  - ready=1, ser_valid=0.
  - start=1 at edge t: latch data_in into the shift register, clear fold and count, go to DATA.
  - First bit (data_in[N-1]) is valid from cycle t+1.
  - shift is ignored in IDLE.
- DATA:
  - ser_out = shift register MSB. ready=0.
  - On an edge with shift=1, let d = ser_out:
    - fold <= {d ^ fold[0], fold[14:1]};
    - shift register <= shift register << 1;
    - count <= count+1.
  - When count=N-1 and shift=1, go to CHECK.
  - shift=0 holds everything; ser_out is stable.
- CHECK:
  - ser_out = fold[0], i.e. check bits are sent LSB first.
  - On shift=1: fold <= {1'b0, fold[14:1]}; count <= count+1.
  - frame_last=1 when count=N+14.
  - When frame_last and shift=1, go to IDLE; ready=1 the next cycle.
- start while ready=0 is ignored; data_in is not resampled.
- start coincident with rst: rst wins.
- A back-to-back frame costs one IDLE cycle: start is sampled the cycle ready returns.
- check_out during DATA equals the value the receive-side register holds after the same count bits.
- check_out is frozen (not cleared) on return to IDLE until the next start.
  - Exception: in CHECK it decays, because the fold register shifts right with zero fill; the last check bit leaves check_out=0.
- Counter arithmetic is unsigned CW-bit. It never wraps because of the N+15 <= 2047 constraint.

Decomposition:
- Package fold_pkg:
  - CHECK_W=15;
  - state enum {IDLE, DATA, CHECK};
  - function fold_step(reg15, bit), which returns {bit ^ reg15[0], reg15[14:1]}.
- fold_step is shared with the receive-side register and the future checker.
- One sub-module: fold_lfsr, the 15-bit register with modes load-zero / fold-in-bit / drain.
- The top level holds the FSM, the data shift register and the counter.

Test Plan:
- Reset then idle, 5 cycles with shift=1:
  - ready=1, ser_valid=0, count=0, check_out=0.
- N=4, data_in=4'b1011, shift held 1:
  - ser_out sequence 1,0,1,1, then 0 x11, 1,0,1,1.
  - check_out after the 4 data bits = 15'h6800.
  - frame_last only on bit 19.
  - ready back at 1 one cycle after it.
- N=64, data_in=64'h1:
  - after 64 data bits check_out=15'h4000.
  - the check phase emits 14 zeros then a 1 with frame_last=1.
  - count peaks at 78.
- N=4, data 4'b1011, shift toggled 1/0 every cycle:
  - same bit sequence as the second scenario; each bit holds 2 cycles.
  - count advances only on shift=1 edges.
- start asserted during DATA with a different data_in:
  - ignored; the frame completes unchanged.
- rst pulsed at count=2 of the CHECK phase:
  - next cycle IDLE, ready=1, ser_valid=0, check_out=0.
  - a following start sends a clean frame.
